quadrature_encoder_gen: RTL



---
 rtl/quadrature_encoder_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B generator: accepts a step command over valid/ready and emits
// full Gray-code cycles with a programmable spacing between edges.
module quadrature_encoder_gen #(
   parameter int REG_LEN    = 8,
   parameter int PERIOD_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_dir,
   input  logic [REG_LEN-1:0]    cmd_steps,
   input  logic [PERIOD_LEN-1:0] cmd_period,
   input  logic                  abort,
   output logic                  rotary_a,
   output logic                  rotary_b,
   output logic                  busy,
   output logic                  done,
   output logic [REG_LEN-1:0]    steps_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                  state_q, state_d;
   logic                    dir_q, dir_d;
   logic [REG_LEN-1:0]      steps_q, steps_d;
   logic [PERIOD_LEN-1:0]   reload_q, reload_d;
   logic [PERIOD_LEN-1:0]   cnt_q, cnt_d;
   logic [1:0]              quarter_q, quarter_d;
   logic                    abort_q, abort_d;
   logic                    a_q, a_d;
   logic                    b_q, b_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [REG_LEN-1:0]      steps_done_q, steps_done_d;

   logic                    accept;
   logic                    tick;
   logic                    stop_now;
   logic                    step_end;
   logic                    last_step;
   logic [1:0]              quarter_nxt;
   logic [REG_LEN-1:0]      steps_inc;
   logic [PERIOD_LEN-1:0]   cmd_reload;

   assign cmd_ready   = (state_q == IDLE) & ~rst;
   assign accept      = cmd_valid & cmd_ready;
   assign tick        = (state_q == RUN) && (cnt_q == '0);
   // A latched abort on the rest phase stops before any further edge.
   assign stop_now    = (state_q == RUN) && abort_q && (quarter_q == 2'd0);
   assign step_end    = tick && (quarter_q == 2'd3);
   assign steps_inc   = steps_done_q + REG_LEN'(1);
   assign last_step   = step_end && ((steps_inc == steps_q) || abort_q);
   assign quarter_nxt = quarter_q + 2'd1;
   assign cmd_reload  = (cmd_period == '0) ? '0 : cmd_period - PERIOD_LEN'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (cmd_steps == '0) ? DONE : RUN;
         RUN:     if (stop_now || last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dir_d        = dir_q;
      steps_d      = steps_q;
      reload_d     = reload_q;
      cnt_d        = cnt_q;
      quarter_d    = quarter_q;
      abort_d      = abort_q;
      a_d          = a_q;
      b_d          = b_q;
      steps_done_d = steps_done_q;
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
      case (state_q)
         IDLE: begin
            if (accept) begin
               dir_d        = cmd_dir;
               steps_d      = cmd_steps;
               reload_d     = cmd_reload;
               cnt_d        = cmd_reload;
               quarter_d    = 2'd0;
               abort_d      = 1'b0;
               steps_done_d = '0;
            end
         end
         RUN: begin
            abort_d = abort_q | abort;
            if (!stop_now) begin
               if (tick) begin
                  cnt_d     = reload_q;
                  quarter_d = quarter_nxt;
                  // Quarter index maps onto the Gray phase; direction swaps A and B.
                  a_d = dir_q ? (quarter_nxt[1] ^ quarter_nxt[0]) : quarter_nxt[1];
                  b_d = dir_q ? quarter_nxt[1] : (quarter_nxt[1] ^ quarter_nxt[0]);
                  if (step_end) steps_done_d = steps_inc;
               end else begin
                  cnt_d = cnt_q - PERIOD_LEN'(1);
               end
            end
         end
         DONE:    abort_d = 1'b0;
         default: abort_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q        <= 1'b0;
         steps_q      <= '0;
         reload_q     <= '0;
         cnt_q        <= '0;
         quarter_q    <= 2'd0;
         abort_q      <= 1'b0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         steps_done_q <= '0;
      end else begin
         dir_q        <= dir_d;
         steps_q      <= steps_d;
         reload_q     <= reload_d;
         cnt_q        <= cnt_d;
         quarter_q    <= quarter_d;
         abort_q      <= abort_d;
         a_q          <= a_d;
         b_q          <= b_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         steps_done_q <= steps_done_d;
      end
   end

   assign rotary_a   = a_q;
   assign rotary_b   = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign steps_done = steps_done_q;

endmodule
